multicycle_ctrl: RTL and testbench

- Moore/Mealy FSM that sequences a multi-cycle RV32I datapath: FETCH, DECODE, EXEC, MEM, WB.
- Shares one unified memory port between instruction fetch and data access.
- Drives register, PC and ALU strobes per instruction class.
- Handshakes with a variable-latency memory, with a watchdog timeout and a sticky illegal-opcode trap.

---
 rtl/multicycle_ctrl_if.sv | 28 ++
 rtl/multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// multicycle_ctrl_if : unified memory port handshake (shared fetch/data port)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_sel,
    output mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle RV32I
//                   datapath. Optional perf counters: MULTICYCLE_CTRL_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  multicycle_ctrl_if.master mem,
  input  wire logic [6:0]  opcode,
  input  wire logic        branch_taken,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [2:0]       alu_op,
`ifdef MULTICYCLE_CTRL_PERF_EN
  output logic [31:0]      instret,
  output logic [31:0]      mem_wait,
`endif
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  localparam logic [3:0] CL_R     = 4'd0;
  localparam logic [3:0] CL_I     = 4'd1;
  localparam logic [3:0] CL_LW    = 4'd2;
  localparam logic [3:0] CL_SW    = 4'd3;
  localparam logic [3:0] CL_BR    = 4'd4;
  localparam logic [3:0] CL_JAL   = 4'd5;
  localparam logic [3:0] CL_JALR  = 4'd6;
  localparam logic [3:0] CL_LUI   = 4'd7;
  localparam logic [3:0] CL_AUIPC = 4'd8;

  localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(TIMEOUT_CYCLES);

  logic [2:0]      state_q, state_d;
  logic [3:0]      class_q, class_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;

  logic            w_req, w_we, w_sel, w_irw;
  logic            w_legal;
  logic [3:0]      w_dec_class;
  logic            w_wd_expired;

  assign w_wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == C_TIMEOUT);

  always_comb begin
    w_legal     = 1'b1;
    w_dec_class = CL_R;
    case (opcode)
      7'b0110011: w_dec_class = CL_R;
      7'b0010011: w_dec_class = CL_I;
      7'b0000011: w_dec_class = CL_LW;
      7'b0100011: w_dec_class = CL_SW;
      7'b1100011: w_dec_class = CL_BR;
      7'b1101111: w_dec_class = CL_JAL;
      7'b1100111: w_dec_class = CL_JALR;
      7'b0110111: w_dec_class = CL_LUI;
      7'b0010111: w_dec_class = CL_AUIPC;
      default:    w_legal     = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    wd_d      = wd_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    w_req     = 1'b0;
    w_we      = 1'b0;
    w_sel     = 1'b0;
    w_irw     = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    alu_src   = 1'b0;
    alu_op    = 3'b000;

    case (state_q)
      ST_FETCH: begin
        w_req = 1'b1;
        w_irw = mem.mem_ready;
        if (mem.mem_ready) begin
          state_d = ST_DECODE;
        end else if (w_wd_expired) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (w_legal) begin
          class_d = w_dec_class;
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        case (class_q)
          CL_R:     begin alu_op = 3'b010; state_d = ST_WB; end
          CL_I:     begin alu_op = 3'b010; alu_src = 1'b1; state_d = ST_WB; end
          CL_LW,
          CL_SW:    begin alu_op = 3'b000; alu_src = 1'b1; state_d = ST_MEM; end
          CL_BR: begin
            alu_op   = 3'b001;
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b01 : 2'b00;
            state_d  = ST_FETCH;
          end
          CL_JAL: begin
            alu_op    = 3'b100;
            pc_write  = 1'b1;
            pc_src    = 2'b01;
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            state_d   = ST_FETCH;
          end
          CL_JALR: begin
            alu_op    = 3'b101;
            alu_src   = 1'b1;
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            state_d   = ST_FETCH;
          end
          CL_LUI:   begin alu_op = 3'b110; alu_src = 1'b1; state_d = ST_WB; end
          CL_AUIPC: begin alu_op = 3'b111; alu_src = 1'b1; state_d = ST_WB; end
          default:  state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        w_req = 1'b1;
        w_sel = 1'b1;
        w_we  = (class_q == CL_SW);
        if (mem.mem_ready) begin
          if (class_q == CL_SW) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_WB;
          end
        end else if (w_wd_expired) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (class_q == CL_LW) ? 2'b01 : 2'b00;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    // Every fresh memory request starts its wait budget from zero.
    if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
      wd_d = '0;
    end else if (w_req && !mem.mem_ready) begin
      wd_d = wd_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      class_q   <= CL_R;
      wd_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wd_q      <= wd_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Reset state is FETCH, so the request is masked while rst_n is low.
  assign mem.mem_req = w_req & rst_n;
  assign mem.mem_we  = w_we;
  assign mem.mem_sel = w_sel;
  assign ir_write    = w_irw & rst_n;
  assign state       = state_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instret_q, instret_d;
  logic [31:0] mem_wait_q, mem_wait_d;

  always_comb begin
    instret_d  = instret_q;
    mem_wait_d = mem_wait_q;
    if ((state_d == ST_FETCH) &&
        ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB))) begin
      instret_d = instret_q + 32'd1;
    end
    if (w_req && !mem.mem_ready) begin
      mem_wait_d = mem_wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q  <= '0;
      mem_wait_q <= '0;
    end else begin
      instret_q  <= instret_d;
      mem_wait_q <= mem_wait_d;
    end
  end

  assign instret  = instret_q;
  assign mem_wait = mem_wait_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : table-driven + hand-sequenced check of multicycle_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       ir_write, pc_write, reg_write, alu_src, illegal, timeout;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] alu_op, state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instret, mem_wait;
`endif

  multicycle_ctrl_if mif ();

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mif),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
`ifdef MULTICYCLE_CTRL_PERF_EN
    .instret      (instret),
    .mem_wait     (mem_wait),
`endif
    .state        (state),
    .illegal      (illegal),
    .timeout      (timeout)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, sel, irw, pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] wbs;
    logic       asrc;
    logic [2:0] aop;
    logic       ill, to;
  } obs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic       br;
    int         fw;
    int         mw;
    logic [2:0] aop;
    logic       asrc;
    logic       xpcw;
    logic [1:0] xpcs;
    logic       xrw;
    logic [1:0] xwbs;
    logic       has_mem;
    logic       we;
    logic       has_wb;
    logic [1:0] wbs;
  } vec_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   retired  = 0;
  int   wait_cyc = 0;
  vec_t tbl[13];

  function automatic obs_t sample();
    obs_t a;
    a = '{st: state, req: mif.mem_req, we: mif.mem_we, sel: mif.mem_sel,
          irw: ir_write, pcw: pc_write, pcs: pc_src, rw: reg_write,
          wbs: wb_sel, asrc: alu_src, aop: alu_op, ill: illegal, to: timeout};
    return a;
  endfunction

  function automatic obs_t mk(input logic [2:0] st);
    obs_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  task automatic check(input string tag);
    obs_t e, a;
    e = exp_q.pop_front();
    a = sample();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, a, e);
    end
  endtask

  // Inputs are applied just after posedge; outputs are compared at negedge.
  task automatic step(input logic [6:0] op, input logic br, input logic rdy,
                      input obs_t e, input string tag);
    opcode        = op;
    branch_taken  = br;
    mif.mem_ready = rdy;
    exp_q.push_back(e);
    if (e.req && !rdy) wait_cyc++;
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    obs_t e;
    rst_n         = 1'b0;
    mif.mem_ready = 1'b0;
    branch_taken  = 1'b0;
    opcode        = 7'b0;
    #2;
    e = mk(3'd0);
    exp_q.push_back(e);
    check(tag);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    retired  = 0;
    wait_cyc = 0;
  endtask

  task automatic run(input vec_t v);
    obs_t e;
    for (int i = 0; i < v.fw; i++) begin
      e = mk(3'd0); e.req = 1'b1;
      step(v.op, v.br, 1'b0, e, {v.name, " fetch-wait"});
    end
    e = mk(3'd0); e.req = 1'b1; e.irw = 1'b1;
    step(v.op, v.br, 1'b1, e, {v.name, " fetch"});
    e = mk(3'd1);
    step(v.op, v.br, 1'b1, e, {v.name, " decode"});
    e = mk(3'd2); e.aop = v.aop; e.asrc = v.asrc; e.pcw = v.xpcw;
    e.pcs = v.xpcs; e.rw = v.xrw; e.wbs = v.xwbs;
    step(v.op, v.br, 1'b1, e, {v.name, " exec"});
    if (v.has_mem) begin
      for (int i = 0; i < v.mw; i++) begin
        e = mk(3'd3); e.req = 1'b1; e.sel = 1'b1; e.we = v.we;
        step(v.op, v.br, 1'b0, e, {v.name, " mem-wait"});
      end
      e = mk(3'd3); e.req = 1'b1; e.sel = 1'b1; e.we = v.we; e.pcw = v.we;
      step(v.op, v.br, 1'b1, e, {v.name, " mem"});
    end
    if (v.has_wb) begin
      e = mk(3'd4); e.rw = 1'b1; e.wbs = v.wbs; e.pcw = 1'b1;
      step(v.op, v.br, 1'b1, e, {v.name, " wb"});
    end
    retired++;
  endtask

  initial begin
    obs_t e;
    //            name        op          br  fw mw aop     as  xpcw xpcs   xrw  xwbs   mem we  wb  wbs
    tbl[0]  = '{"R",      7'b0110011, 1'b1, 0, 0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[1]  = '{"I",      7'b0010011, 1'b0, 0, 0, 3'b010, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[2]  = '{"LW",     7'b0000011, 1'b0, 0, 3, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[3]  = '{"SW",     7'b0100011, 1'b0, 0, 0, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00};
    tbl[4]  = '{"BR-t",   7'b1100011, 1'b1, 0, 0, 3'b001, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[5]  = '{"BR-nt",  7'b1100011, 1'b0, 0, 0, 3'b001, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[6]  = '{"JAL",    7'b1101111, 1'b0, 0, 0, 3'b100, 1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[7]  = '{"JALR",   7'b1100111, 1'b1, 0, 0, 3'b101, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[8]  = '{"LUI",    7'b0110111, 1'b0, 0, 0, 3'b110, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[9]  = '{"AUIPC",  7'b0010111, 1'b0, 0, 0, 3'b111, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[10] = '{"R-fw4",  7'b0110011, 1'b0, 4, 0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[11] = '{"LW-edge",7'b0000011, 1'b0, 3, 4, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[12] = '{"SW-w2",  7'b0100011, 1'b1, 1, 2, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00};

    rst_n         = 1'b0;
    mif.mem_ready = 1'b0;
    opcode        = 7'b0;
    branch_taken  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset-idle");

    for (int i = 0; i < 13; i++) run(tbl[i]);

`ifdef MULTICYCLE_CTRL_PERF_EN
    total++;
    if (instret !== 32'(retired)) begin
      bad++;
      $display("FAIL instret: got %0d expected %0d", instret, retired);
    end
    total++;
    if (mem_wait !== 32'(wait_cyc)) begin
      bad++;
      $display("FAIL mem_wait: got %0d expected %0d", mem_wait, wait_cyc);
    end
`endif

    // Reset during an outstanding fetch drops the request at once.
    e = mk(3'd0); e.req = 1'b1;
    step(7'b0110011, 1'b0, 1'b0, e, "pre-reset fetch");
    do_reset("reset-mid-fetch");

    // Illegal opcode: sticky TRAP with all strobes quiet.
    e = mk(3'd0); e.req = 1'b1; e.irw = 1'b1;
    step(7'b1111111, 1'b0, 1'b1, e, "ill fetch");
    e = mk(3'd1);
    step(7'b1111111, 1'b0, 1'b1, e, "ill decode");
    for (int i = 0; i < 20; i++) begin
      e = mk(3'd7); e.ill = 1'b1;
      step(7'b1111111, 1'b1, 1'b1, e, "ill trap");
    end
    do_reset("reset-after-illegal");

    // Fetch watchdog: count 0..4 with no ready, then TRAP.
    for (int i = 0; i < 5; i++) begin
      e = mk(3'd0); e.req = 1'b1;
      step(7'b0110011, 1'b0, 1'b0, e, "fetch timeout wait");
    end
    for (int i = 0; i < 3; i++) begin
      e = mk(3'd7); e.to = 1'b1;
      step(7'b0110011, 1'b0, 1'b1, e, "fetch timeout trap");
    end
    do_reset("reset-after-timeout");

    // Data watchdog on a load that never completes.
    e = mk(3'd0); e.req = 1'b1; e.irw = 1'b1;
    step(7'b0000011, 1'b0, 1'b1, e, "lw-to fetch");
    e = mk(3'd1);
    step(7'b0000011, 1'b0, 1'b0, e, "lw-to decode");
    e = mk(3'd2); e.asrc = 1'b1;
    step(7'b0000011, 1'b0, 1'b0, e, "lw-to exec");
    for (int i = 0; i < 5; i++) begin
      e = mk(3'd3); e.req = 1'b1; e.sel = 1'b1;
      step(7'b0000011, 1'b0, 1'b0, e, "lw-to mem wait");
    end
    e = mk(3'd7); e.to = 1'b1;
    step(7'b0000011, 1'b0, 1'b1, e, "lw-to trap");
    do_reset("reset-final");

    // Ready on the expiry cycle still completes normally after a trap/reset.
    run(tbl[10]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1);
  end

endmodule

`default_nettype wire
